// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the compare-to-zero branch resolver: opcodes and FSM states.
package branch_resolve_ctrl_pkg;

  localparam logic [4:0] OP_BNEZ = 5'b01100;
  localparam logic [4:0] OP_BEQZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_OPND = 2'd1,
    S_RESOLVE   = 2'd2,
    S_REDIRECT  = 2'd3
  } state_t;

  // The four branch opcodes are exactly the 5'b011xx group.
  function automatic logic is_branch(input logic [4:0] op);
    return (op[4:2] == 3'b011);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_cond.sv
// Flag derivation and branch condition evaluation for the compare-to-zero branches.
module branch_cond_eval
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] operand,
  output logic              taken
);

  logic eq;
  logic lt;
  logic gt;

  // Derive eq/lt/gt from the signed operand and select the condition by opcode.
  always_comb begin
    eq    = (operand == '0);
    lt    = operand[DATA_W-1];
    gt    = ~lt & ~eq;
    taken = 1'b0;
    case (opcode)
      OP_BNEZ: taken = ~eq;
      OP_BEQZ: taken = eq;
      OP_BLTZ: taken = lt;
      OP_BGEZ: taken = gt | eq;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer between decode and fetch: captures a branch, waits for its
// operand, resolves it, and issues a held redirect plus one-cycle flush when taken.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_opcode,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [OFF_W-1:0]  id_offset,
  output logic              id_ready,
  input  logic              opnd_valid,
  input  logic [DATA_W-1:0] opnd_data,
  input  logic              kill,
  output logic              stall_fetch,
  output logic              flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ack,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  state_t              state;
  state_t              state_next;
  logic                capture;
  logic                opnd_load;
  logic [4:0]          op_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [OFF_W-1:0]    off_q;
  logic [DATA_W-1:0]   opnd_q;
  logic                taken;
  logic [ADDR_W-1:0]   target;

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .opcode  (op_q),
    .operand (opnd_q),
    .taken   (taken)
  );

  // Target wraps modulo 2^ADDR_W; offset is sign-extended.
  assign target = pc_q + ADDR_W'(1) + {{(ADDR_W-OFF_W){off_q[OFF_W-1]}}, off_q};

  // Handshake outputs are decoded from state only, so no input reaches them combinationally.
  assign id_ready    = (state == S_IDLE);
  assign stall_fetch = (state != S_IDLE);

  // Next-state and capture decode; kill overrides every transition and any capture.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    opnd_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (id_valid && is_branch(id_opcode)) begin
          capture    = 1'b1;
          opnd_load  = opnd_valid;
          state_next = opnd_valid ? S_RESOLVE : S_WAIT_OPND;
        end
      end
      S_WAIT_OPND: begin
        if (opnd_valid) begin
          opnd_load  = 1'b1;
          state_next = S_RESOLVE;
        end
      end
      S_RESOLVE:  state_next = taken ? S_REDIRECT : S_IDLE;
      S_REDIRECT: if (redirect_ack) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
    if (kill) begin
      state_next = S_IDLE;
      capture    = 1'b0;
      opnd_load  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Latch the branch fields at capture and the operand when it becomes valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      pc_q   <= '0;
      off_q  <= '0;
      opnd_q <= '0;
    end else begin
      if (capture) begin
        op_q  <= id_opcode;
        pc_q  <= id_pc;
        off_q <= id_offset;
      end
      if (opnd_load) opnd_q <= opnd_data;
    end
  end

  // Registered redirect/flush outputs and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      br_count       <= '0;
      taken_count    <= '0;
    end else begin
      flush <= 1'b0;
      if (kill) begin
        redirect_valid <= 1'b0;
      end else if (state == S_RESOLVE && taken) begin
        redirect_valid <= 1'b1;
        flush          <= 1'b1;
        redirect_pc    <= target;
      end else if (state == S_REDIRECT && redirect_ack) begin
        redirect_valid <= 1'b0;
      end
      if (state == S_RESOLVE && !kill) begin
        if (br_count != '1) br_count <= br_count + CNT_W'(1);
        if (taken && taken_count != '1) taken_count <= taken_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl against a transaction-level reference model.
module tb_branch_resolve_ctrl;

  localparam int SAT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_opcode;
  logic [15:0] id_pc;
  logic [10:0] id_offset;
  logic        opnd_valid;
  logic [15:0] opnd_data;
  logic        kill;
  logic        redirect_ack;

  logic        id_ready, stall_fetch, flush, redirect_valid;
  logic [15:0] redirect_pc, br_count, taken_count;

  logic        s_id_ready, s_stall_fetch, s_flush, s_redirect_valid;
  logic [15:0] s_redirect_pc;
  logic [SAT_W-1:0] s_br_count, s_taken_count;

  int checks = 0;
  int passed = 0;
  int n_br = 0;
  int n_taken = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.DATA_W(16), .ADDR_W(16), .OFF_W(11), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_pc(id_pc),
    .id_offset(id_offset), .id_ready(id_ready), .opnd_valid(opnd_valid), .opnd_data(opnd_data),
    .kill(kill), .stall_fetch(stall_fetch), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ack(redirect_ack), .br_count(br_count),
    .taken_count(taken_count)
  );

  branch_resolve_ctrl #(.DATA_W(16), .ADDR_W(16), .OFF_W(11), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_pc(id_pc),
    .id_offset(id_offset), .id_ready(s_id_ready), .opnd_valid(opnd_valid), .opnd_data(opnd_data),
    .kill(kill), .stall_fetch(s_stall_fetch), .flush(s_flush), .redirect_valid(s_redirect_valid),
    .redirect_pc(s_redirect_pc), .redirect_ack(redirect_ack), .br_count(s_br_count),
    .taken_count(s_taken_count)
  );

  function automatic bit model_taken(input logic [4:0] op, input logic [15:0] v);
    int s;
    s = $signed(v);
    case (op)
      5'b01100: return s != 0;
      5'b01101: return s == 0;
      5'b01110: return s < 0;
      5'b01111: return s >= 0;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] model_target(input logic [15:0] pc, input logic [10:0] off);
    int p, o, t;
    p = pc;
    o = $signed(off);
    t = p + 1 + o;
    return 16'(t);
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    checks++;
    if (br_count !== 16'(sat(n_br, 16)) || s_br_count !== SAT_W'(sat(n_br, SAT_W)))
      $display("FAIL %s_br_count: got %0d/%0d exp %0d/%0d", tag, br_count, s_br_count,
               sat(n_br, 16), sat(n_br, SAT_W));
    else passed++;
    checks++;
    if (taken_count !== 16'(sat(n_taken, 16)) || s_taken_count !== SAT_W'(sat(n_taken, SAT_W)))
      $display("FAIL %s_taken_count: got %0d/%0d exp %0d/%0d", tag, taken_count, s_taken_count,
               sat(n_taken, 16), sat(n_taken, SAT_W));
    else passed++;
  endtask

  // Drives one complete branch: w cycles of operand wait, ack after ack_dly extra redirect cycles.
  task automatic run_branch(input logic [4:0] op, input logic [15:0] pc, input logic [10:0] off,
                            input logic [15:0] data, input int unsigned w,
                            input int unsigned ack_dly, input string tag);
    bit          tk;
    logic [15:0] tgt;
    int unsigned stalls, exp_stalls;
    tk = model_taken(op, data);
    tgt = model_target(pc, off);
    stalls = 0;
    exp_stalls = w + 1 + (tk ? ack_dly + 1 : 0);
    checks++;
    if (id_ready !== 1'b1 || stall_fetch !== 1'b0)
      $display("FAIL %s_idle_before: id_ready=%b stall=%b exp 1/0", tag, id_ready, stall_fetch);
    else passed++;
    id_valid = 1'b1; id_opcode = op; id_pc = pc; id_offset = off;
    opnd_valid = (w == 0);
    opnd_data = (w == 0) ? data : 16'($urandom);
    step();
    id_valid = 1'b0; id_opcode = 5'($urandom); id_pc = 16'($urandom); id_offset = 11'($urandom);
    for (int unsigned i = 1; i <= w; i++) begin
      if (stall_fetch) stalls++;
      checks++;
      if (redirect_valid !== 1'b0 || id_ready !== 1'b0)
        $display("FAIL %s_wait: redirect_valid=%b id_ready=%b exp 0/0", tag, redirect_valid, id_ready);
      else passed++;
      opnd_valid = (i == w);
      opnd_data = (i == w) ? data : 16'($urandom);
      step();
    end
    opnd_valid = 1'b0; opnd_data = 16'($urandom);
    if (stall_fetch) stalls++;
    checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0)
      $display("FAIL %s_resolve: redirect_valid=%b flush=%b exp 0/0", tag, redirect_valid, flush);
    else passed++;
    step();
    n_br++;
    if (tk) n_taken++;
    check_counters(tag);
    if (tk) begin
      for (int unsigned k = 0; k <= ack_dly; k++) begin
        if (stall_fetch) stalls++;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== tgt || flush !== (k == 0))
          $display("FAIL %s_redirect: cyc %0d valid=%b pc=%h flush=%b exp 1/%h/%b", tag, k,
                   redirect_valid, redirect_pc, flush, tgt, (k == 0));
        else passed++;
        redirect_ack = (k == ack_dly);
        step();
      end
      redirect_ack = 1'b0;
    end
    checks++;
    if (stall_fetch !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0)
      $display("FAIL %s_idle_after: stall=%b valid=%b flush=%b exp 0/0/0", tag, stall_fetch,
               redirect_valid, flush);
    else passed++;
    checks++;
    if (stalls != exp_stalls)
      $display("FAIL %s_stall_cycles: got %0d exp %0d", tag, stalls, exp_stalls);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_pc = '0; id_offset = '0;
    opnd_valid = 1'b0; opnd_data = '0; kill = 1'b0; redirect_ack = 1'b0;
    repeat (3) step();
    checks++;
    if (id_ready !== 1'b1 || stall_fetch !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0 ||
        redirect_pc !== 16'h0 || br_count !== 16'h0 || taken_count !== 16'h0)
      $display("FAIL reset_values: rdy=%b stall=%b flush=%b rv=%b pc=%h br=%h tk=%h", id_ready,
               stall_fetch, flush, redirect_valid, redirect_pc, br_count, taken_count);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_beqz_taken();
    run_branch(5'b01101, 16'h0010, 11'sd4, 16'h0000, 0, 0, "beqz");
  endtask

  task automatic test_wait_not_taken();
    run_branch(5'b01100, 16'h0100, 11'h7F0, 16'h0000, 4, 0, "bnez_wait");
  endtask

  task automatic test_mixed_conditions();
    run_branch(5'b01110, 16'h0200, 11'h005, 16'h8000, 0, 1, "bltz");
    run_branch(5'b01111, 16'h0300, 11'h7FF, 16'h0000, 1, 0, "bgez_zero");
    run_branch(5'b01111, 16'h0400, 11'h010, 16'hFFFF, 2, 0, "bgez_neg");
  endtask

  task automatic test_wrap_hold();
    run_branch(5'b01101, 16'hFFFF, 11'h000, 16'h0000, 0, 4, "wrap");
  endtask

  task automatic test_ignored();
    id_valid = 1'b1; opnd_valid = 1'b1; opnd_data = 16'h0000;
    id_opcode = 5'b01011;
    step();
    checks++;
    if (stall_fetch !== 1'b0) $display("FAIL ignore_01011: stall=%b exp 0", stall_fetch);
    else passed++;
    id_opcode = 5'b11101;
    step();
    checks++;
    if (stall_fetch !== 1'b0) $display("FAIL ignore_11101: stall=%b exp 0", stall_fetch);
    else passed++;
    id_valid = 1'b0; opnd_valid = 1'b0;
    step();
  endtask

  task automatic test_kill();
    // Kill in RESOLVE: dropped without counting.
    id_valid = 1'b1; id_opcode = 5'b01101; id_pc = 16'h0040; id_offset = 11'h002;
    opnd_valid = 1'b1; opnd_data = 16'h0000;
    step();
    id_valid = 1'b0; opnd_valid = 1'b0; kill = 1'b1;
    step();
    kill = 1'b0;
    checks++;
    if (stall_fetch !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0)
      $display("FAIL kill_resolve: stall=%b rv=%b flush=%b exp 0/0/0", stall_fetch, redirect_valid, flush);
    else passed++;
    check_counters("kill_resolve");
    // Kill in REDIRECT: branch already counted, redirect withdrawn.
    id_valid = 1'b1; opnd_valid = 1'b1;
    step();
    id_valid = 1'b0; opnd_valid = 1'b0;
    step();
    n_br++; n_taken++;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0043)
      $display("FAIL kill_pre_redirect: rv=%b pc=%h exp 1/0043", redirect_valid, redirect_pc);
    else passed++;
    kill = 1'b1;
    step();
    kill = 1'b0;
    checks++;
    if (stall_fetch !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0)
      $display("FAIL kill_redirect: stall=%b rv=%b flush=%b exp 0/0/0", stall_fetch, redirect_valid, flush);
    else passed++;
    check_counters("kill_redirect");
    // Kill coinciding with capture: capture dropped.
    id_valid = 1'b1; id_opcode = 5'b01100; opnd_valid = 1'b0; kill = 1'b1;
    step();
    id_valid = 1'b0; kill = 1'b0;
    checks++;
    if (stall_fetch !== 1'b0) $display("FAIL kill_capture: stall=%b exp 0", stall_fetch);
    else passed++;
    // Kill while waiting for the operand.
    id_valid = 1'b1;
    step();
    id_valid = 1'b0; kill = 1'b1;
    step();
    kill = 1'b0;
    checks++;
    if (stall_fetch !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL kill_wait: stall=%b rv=%b exp 0/0", stall_fetch, redirect_valid);
    else passed++;
    run_branch(5'b01110, 16'h1234, 11'h400, 16'hC000, 1, 0, "post_kill");
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: d = 16'h0000;
        1: d = 16'h8000;
        2: d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
      run_branch({3'b011, 2'($urandom)}, 16'($urandom), 11'($urandom), d,
                 $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end
  endtask

  task automatic test_saturation();
    checks++;
    if (s_br_count !== '1) $display("FAIL sat_br_full: got %h exp all-ones", s_br_count);
    else passed++;
    run_branch(5'b01101, 16'h0500, 11'h001, 16'h0000, 0, 0, "sat_a");
    run_branch(5'b01111, 16'h0600, 11'h001, 16'h0001, 1, 0, "sat_b");
  endtask

  task automatic test_async_reset();
    id_valid = 1'b1; id_opcode = 5'b01100; id_pc = 16'h0700; id_offset = 11'h003; opnd_valid = 1'b0;
    step();
    id_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_br = 0; n_taken = 0;
    checks++;
    if (id_ready !== 1'b1 || stall_fetch !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0 ||
        redirect_pc !== 16'h0)
      $display("FAIL async_reset: rdy=%b stall=%b flush=%b rv=%b pc=%h", id_ready, stall_fetch,
               flush, redirect_valid, redirect_pc);
    else passed++;
    check_counters("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_branch(5'b01100, 16'h0800, 11'h7FE, 16'h0005, 0, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_beqz_taken();
    test_wait_not_taken();
    test_mixed_conditions();
    test_wrap_hold();
    test_ignored();
    test_kill();
    test_random();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
